// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: captures a binary value, converts it to BCD by double-dabble,
// and scans it onto N common-anode 7-segment digits with blanking, dp, overflow and blink.
module fnd_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_HZ   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_load,
    input  logic [NUM_DIGITS-1:0] i_dp,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic                  o_busy,
    output logic                  o_ovf,
    output logic [NUM_DIGITS-1:0] fnd_com,
    output logic [7:0]            fnd
);
    localparam int SDIV = CLK_HZ / SCAN_HZ;
    localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
    // BCD digits needed to hold any DATA_W-bit value, never fewer than the display width
    localparam int NBCD = ((DATA_W * 3) / 10 + 1 > NUM_DIGITS) ? (DATA_W * 3) / 10 + 1 : NUM_DIGITS;
    localparam int BW   = 4 * NBCD;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CW   = $clog2(DATA_W);
    localparam int SW   = $clog2(SDIV + 1);
    localparam int BCW  = $clog2(BDIV + 1);
    localparam logic [31:0] LIM = 32'(10 ** NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                  r_state;
    logic [DATA_W-1:0]       r_val, r_sh;
    logic [BW-1:0]           r_bcd, w_adj;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [SW-1:0]           r_sdiv;
    logic [BCW-1:0]          r_bdiv;
    logic [IW-1:0]           r_idx;
    logic                    r_phase;
    logic [NUM_DIGITS-1:0]   r_com;
    logic [7:0]              r_fnd;
    logic                    w_stick, w_btick, w_blank;
    logic [3:0]              w_nib;
    logic [6:0]              w_dec, w_seg;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < NBCD; k++)
            w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_sh    <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            o_busy  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_load) begin
                    r_val   <= i_data;
                    r_sh    <= i_data;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    o_busy  <= 1'b1;
                    r_state <= CONV;
                end
                CONV: begin
                    r_bcd <= {w_adj[BW-2:0], r_sh[DATA_W-1]};
                    r_sh  <= r_sh << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DATA_W - 1)) r_state <= DONE;
                end
                DONE: begin
                    r_disp  <= r_bcd[4*NUM_DIGITS-1:0];
                    o_ovf   <= 32'(r_val) >= LIM;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_stick = r_sdiv == SW'(SDIV - 1);
    assign w_btick = r_bdiv == BCW'(BDIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sdiv  <= '0;
            r_bdiv  <= '0;
            r_idx   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_sdiv <= w_stick ? '0 : r_sdiv + 1'b1;
            r_bdiv <= w_btick ? '0 : r_bdiv + 1'b1;
            if (w_stick) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            if (w_btick) r_phase <= ~r_phase;
        end
    end

    assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    assign w_blank = i_blank_lz && (r_idx != '0) && ((r_disp >> {r_idx, 2'b00}) == '0);

    always_comb begin
        case (w_nib)
            4'd0:    w_dec = 7'h40;
            4'd1:    w_dec = 7'h79;
            4'd2:    w_dec = 7'h24;
            4'd3:    w_dec = 7'h30;
            4'd4:    w_dec = 7'h19;
            4'd5:    w_dec = 7'h12;
            4'd6:    w_dec = 7'h02;
            4'd7:    w_dec = 7'h78;
            4'd8:    w_dec = 7'h00;
            4'd9:    w_dec = 7'h10;
            default: w_dec = 7'h7F;
        endcase
    end

    assign w_seg = o_ovf ? 7'h3F : w_blank ? 7'h7F : w_dec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_com <= '1;
            r_fnd <= 8'hFF;
        end else begin
            r_com <= (i_blink_en && r_phase) ? '1 : ~(ONE << r_idx);
            r_fnd <= {~i_dp[r_idx], w_seg};
        end
    end

    assign fnd_com = r_com;
    assign fnd     = r_fnd;
endmodule
